// File: rtl/prog_seq.sv
// prog_seq: program sequencer for the instruction ROM.
// Tracks IDLE/RUN/DONE, steps the program counter, and applies forward or
// backward branches by an unsigned offset with modulo-2^PA wrap-around.
// Optional feature: define PROG_SEQ_CYCLE_COUNT_EN to add the CycleCount
// output, which counts RUN cycles since the last accepted Start.
module prog_seq #(
  parameter int unsigned W  = 8,
  parameter int unsigned PA = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [PA-1:0] StartAddr,
  input  logic          BranchUp,
  input  logic          BranchDown,
  input  logic [W-1:0]  PCTarget,
  input  logic          Ack,
  output logic [PA-1:0] ProgCtr,
  output logic          Running,
  output logic          Done
`ifdef PROG_SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]   CycleCount
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PA-1:0] pc_d;
  logic [PA-1:0] offset;
  logic          start_accept;

  // Offset is zero-extended (or truncated) to the PC width; wrap is implicit.
  assign offset = PA'(PCTarget);

  // Next-state and next-PC selection; Ack outranks BranchDown outranks BranchUp.
  always_comb begin
    state_d      = state_q;
    pc_d         = ProgCtr;
    start_accept = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          start_accept = 1'b1;
          state_d      = RUN;
          pc_d         = StartAddr;
        end
      end
      RUN: begin
        if (Ack) begin
          state_d = DONE;
        end else if (BranchDown) begin
          pc_d = ProgCtr + offset;
        end else if (BranchUp) begin
          pc_d = ProgCtr - offset;
        end else begin
          pc_d = ProgCtr + PA'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // State and program counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      ProgCtr <= '0;
    end else begin
      state_q <= state_d;
      ProgCtr <= pc_d;
    end
  end

  assign Running = (state_q == RUN);
  assign Done    = (state_q == DONE);

`ifdef PROG_SEQ_CYCLE_COUNT_EN
  logic [15:0] cnt_d;

  // Cycle counter: cleared on accepted Start, saturating increment in RUN.
  always_comb begin
    cnt_d = CycleCount;
    if (start_accept) begin
      cnt_d = '0;
    end else if (state_q == RUN && CycleCount != 16'hFFFF) begin
      cnt_d = CycleCount + 16'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      CycleCount <= '0;
    end else begin
      CycleCount <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_prog_seq.sv
// tb_prog_seq: self-checking bench for prog_seq with a behavioural model,
// directed scenarios with literal expectations, and randomized stimulus.
module tb_prog_seq;

  localparam int unsigned W   = 8;
  localparam int unsigned PA  = 10;
  localparam int          MOD = 1 << PA;

  logic          Clk;
  logic          Reset;
  logic          Start;
  logic [PA-1:0] StartAddr;
  logic          BranchUp;
  logic          BranchDown;
  logic [W-1:0]  PCTarget;
  logic          Ack;
  logic [PA-1:0] ProgCtr;
  logic          Running;
  logic          Done;
`ifdef PROG_SEQ_CYCLE_COUNT_EN
  logic [15:0]   CycleCount;
`endif

  prog_seq #(.W(W), .PA(PA)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .BranchUp   (BranchUp),
    .BranchDown (BranchDown),
    .PCTarget   (PCTarget),
    .Ack        (Ack),
    .ProgCtr    (ProgCtr),
    .Running    (Running),
    .Done       (Done)
`ifdef PROG_SEQ_CYCLE_COUNT_EN
    ,
    .CycleCount (CycleCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: "busy" means a program is executing, "halted" means it finished.
  int m_pc     = 0;
  bit m_busy   = 0;
  bit m_halted = 0;
  int m_cnt    = 0;
  bit m_valid  = 0;

  function automatic int wrap(input int v);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model update on each edge from the inputs presented, then compare just after.
  always @(posedge Clk) begin
    if (Reset) begin
      m_pc = 0; m_busy = 0; m_halted = 0; m_cnt = 0; m_valid = 1;
    end else if (!m_busy) begin
      if (Start) begin
        m_pc = int'(StartAddr); m_busy = 1; m_halted = 0; m_cnt = 0;
      end
    end else begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (Ack) begin
        m_busy = 0; m_halted = 1;
      end else if (BranchDown) begin
        m_pc = wrap(m_pc + int'(PCTarget));
      end else if (BranchUp) begin
        m_pc = wrap(m_pc - int'(PCTarget));
      end else begin
        m_pc = wrap(m_pc + 1);
      end
    end
    #1;
    if (m_valid) begin
      chk("model_pc", int'(ProgCtr), m_pc);
      chk("model_running", int'(Running), int'(m_busy));
      chk("model_done", int'(Done), int'(m_halted));
`ifdef PROG_SEQ_CYCLE_COUNT_EN
      chk("model_cyclecount", int'(CycleCount), m_cnt);
`endif
    end
  end

  // Present one cycle of inputs and return just after the following edge.
  task automatic step(input logic rst, input logic st, input int addr,
                      input logic bu, input logic bd, input int tgt, input logic ack);
    @(negedge Clk);
    Reset      = rst;
    Start      = st;
    StartAddr  = PA'(addr);
    BranchUp   = bu;
    BranchDown = bd;
    PCTarget   = W'(tgt);
    Ack        = ack;
    @(posedge Clk);
    #2;
  endtask

  task automatic lit(input string name, input int pc, input int run, input int dn);
    chk({name, "_pc"}, int'(ProgCtr), pc);
    chk({name, "_running"}, int'(Running), run);
    chk({name, "_done"}, int'(Done), dn);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; StartAddr = '0; BranchUp = 1'b0;
    BranchDown = 1'b0; PCTarget = '0; Ack = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 1, 1, 5, 1);
    lit("reset", 0, 0, 0);
`ifdef PROG_SEQ_CYCLE_COUNT_EN
    chk("reset_cyclecount", int'(CycleCount), 0);
`endif
    // Branch/Ack inputs ignored in IDLE
    step(0, 0, 9, 1, 1, 33, 1);
    lit("idle_hold", 0, 0, 0);

    // Start at 5, then sequential stepping
    step(0, 1, 5, 0, 0, 0, 0);
    lit("start5", 5, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0); lit("seq6", 6, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0); lit("seq7", 7, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0); lit("seq8", 8, 1, 0);

    // Halt, then restart at 20 for branch tests
    step(0, 0, 0, 0, 0, 0, 1); lit("halt8", 8, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0); lit("done_hold", 8, 0, 1);
    step(0, 1, 20, 0, 0, 0, 0); lit("start20", 20, 1, 0);
    step(0, 0, 0, 0, 1, 12, 0); lit("bdown12", 32, 1, 0);
    step(0, 0, 0, 1, 0, 30, 0); lit("bup30", 2, 1, 0);

    // Wrap-around in both directions
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 'h3FE, 0, 0, 0, 0); lit("start3fe", 'h3FE, 1, 0);
    step(0, 0, 0, 0, 1, 5, 0); lit("wrap_fwd", 3, 1, 0);
    step(0, 0, 0, 1, 0, 2, 0); lit("back_to1", 1, 1, 0);
    step(0, 0, 0, 1, 0, 4, 0); lit("wrap_back", 'h3FD, 1, 0);

    // Ack beats BranchDown at 40, after four RUN cycles
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 37, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0); lit("at40", 40, 1, 0);
    step(0, 0, 0, 0, 1, 7, 1); lit("ack_bd", 40, 0, 1);
`ifdef PROG_SEQ_CYCLE_COUNT_EN
    chk("ack_cyclecount", int'(CycleCount), 4);
`endif
    step(0, 1, 0, 0, 0, 0, 0); lit("restart0", 0, 1, 0);
`ifdef PROG_SEQ_CYCLE_COUNT_EN
    chk("restart_cyclecount", int'(CycleCount), 0);
`endif

    // BranchDown beats BranchUp; Start ignored in RUN; zero offset self-loop
    step(0, 0, 0, 0, 1, 9, 0); lit("to9", 9, 1, 0);
    step(0, 0, 0, 1, 1, 3, 0); lit("both_br", 12, 1, 0);
    step(0, 1, 100, 0, 0, 0, 0); lit("start_in_run", 13, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0); lit("selfloop_dn", 13, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0); lit("selfloop_up", 13, 1, 0);

    // Reset mid-RUN overrides Start and Ack
    step(1, 1, 50, 0, 1, 4, 1); lit("reset_midrun", 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      logic r_rst, r_st, r_bu, r_bd, r_ack;
      int   r_tgt;
      r_rst = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 3) == 0);
      r_bu  = ($urandom_range(0, 2) == 0);
      r_bd  = ($urandom_range(0, 2) == 0);
      r_ack = ($urandom_range(0, 15) == 0);
      r_tgt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      step(r_rst, r_st, int'($urandom_range(0, MOD - 1)), r_bu, r_bd, r_tgt, r_ack);
    end

    @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
